// File: rtl/divider_share_ctrl.sv
// -----------------------------------------------------------------------------
// divider_share_ctrl
//
// Time-shares one non-restoring divide iteration unit between two requesters.
// A round-robin arbiter picks a requester while idle, the operands are loaded,
// one quotient bit is produced per cycle, the remainder gets its final
// correction, and the result (quotient, remainder, requester id) is returned
// over a valid/ready port.
//
// Parameters
//   DW  dividend / quotient / remainder width
//   VW  divisor width (VW <= DW)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   req_valid  per-requester request valid (bit i = requester i)
//   req_ready  per-requester accept, one-hot or zero, combinational in IDLE
//   req_a      dividends, requester i at [i*DW +: DW]
//   req_b      divisors,  requester i at [i*VW +: VW]
//   out_valid  result valid
//   out_ready  result consumer ready
//   out_quot   quotient
//   out_rem    remainder, always in 0..B-1 (B = 0 gives rem = A)
//   out_id     requester index of the result
//   out_div0   divisor was zero (only with DIVZERO_DETECT_EN, else 0)
//   busy       high in every state except IDLE
//
// Build option
//   DIVZERO_DETECT_EN  when defined, a zero divisor bypasses the iterations
//                      and the result is presented on the accepting edge with
//                      out_div0 set. When undefined, a zero divisor runs the
//                      normal iterations (quot = all ones, rem = A) and
//                      out_div0 stays 0.
// -----------------------------------------------------------------------------
module divider_share_ctrl #(
   parameter int DW = 4,
   parameter int VW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*DW-1:0]   req_a,
   input  logic [2*VW-1:0]   req_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_quot,
   output logic [DW-1:0]     out_rem,
   output logic              out_id,
   output logic              out_div0,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t          state, state_nxt;
   logic            last, last_nxt;        // requester granted most recently
   logic [DW-1:0]   q, q_nxt;              // dividend bits out, quotient bits in
   logic [VW-1:0]   b, b_nxt;              // latched divisor
   logic [DW:0]     p, p_nxt;              // partial remainder, two's complement
   logic [CW-1:0]   cnt, cnt_nxt;          // iteration counter
   logic            id, id_nxt;            // requester of the operation in flight
   logic            valid_nxt;
   logic [DW-1:0]   quot_nxt, rem_nxt;
   logic            oid_nxt;
   logic            div0_q, div0_nxt;

   // ---------------------------------------------------------------------------
   // Round-robin arbitration (only meaningful in IDLE)
   // ---------------------------------------------------------------------------
   logic            gnt;
   logic            accept;
   logic [DW-1:0]   a_sel;
   logic [VW-1:0]   b_sel;

   always_comb begin
      // When both request, favour the one that was not served last.
      gnt = 1'b0;
      if (req_valid == 2'b11) gnt = ~last;
      else                    gnt = req_valid[1];
   end

   assign req_ready = (state == IDLE && req_valid != 2'b00) ?
                      (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign a_sel     = gnt ? req_a[2*DW-1:DW] : req_a[DW-1:0];
   assign b_sel     = gnt ? req_b[2*VW-1:VW] : req_b[VW-1:0];

   // ---------------------------------------------------------------------------
   // Non-restoring iteration datapath
   // ---------------------------------------------------------------------------
   // P needs DW+1 bits: 2P + next bit can reach 2B-1 while B is up to 2^VW-1,
   // and with B = 0 it accumulates the whole dividend, so DW bits overflow.
   logic [DW:0]     b_ext;
   logic [DW:0]     p_shift;
   logic [DW:0]     p_step;
   logic [DW:0]     p_fix;

   assign b_ext   = {{(DW+1-VW){1'b0}}, b};
   assign p_shift = {p[DW-1:0], q[DW-1]};
   assign p_step  = p[DW] ? (p_shift + b_ext) : (p_shift - b_ext);
   assign p_fix   = p[DW] ? (p + b_ext) : p;

   assign busy     = (state != IDLE);
   assign out_div0 = div0_q;

   // ---------------------------------------------------------------------------
   // Next-state and next-register logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here is given its hold value first, so no
      // path through the case leaves one unassigned and no latch is inferred.
      state_nxt = state;
      last_nxt  = last;
      q_nxt     = q;
      b_nxt     = b;
      p_nxt     = p;
      cnt_nxt   = cnt;
      id_nxt    = id;
      valid_nxt = out_valid;
      quot_nxt  = out_quot;
      rem_nxt   = out_rem;
      oid_nxt   = out_id;
      div0_nxt  = div0_q;

      case (state)
         IDLE: begin
            if (accept) begin
               q_nxt     = a_sel;
               b_nxt     = b_sel;
               id_nxt    = gnt;
               last_nxt  = gnt;
               p_nxt     = '0;
               cnt_nxt   = '0;
               state_nxt = CALC;
`ifdef DIVZERO_DETECT_EN
               // Zero divisor: answer immediately instead of iterating.
               if (b_sel == '0) begin
                  quot_nxt  = '1;
                  rem_nxt   = a_sel;
                  oid_nxt   = gnt;
                  div0_nxt  = 1'b1;
                  valid_nxt = 1'b1;
                  state_nxt = DONE;
               end
`endif
            end
         end

         CALC: begin
            p_nxt   = p_step;
            q_nxt   = {q[DW-2:0], ~p_step[DW]};
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(DW-1)) state_nxt = FIX;
         end

         FIX: begin
            // A negative final partial remainder is one divisor short.
            p_nxt     = p_fix;
            quot_nxt  = q;
            rem_nxt   = p_fix[DW-1:0];
            oid_nxt   = id;
            div0_nxt  = 1'b0;
            valid_nxt = 1'b1;
            state_nxt = DONE;
         end

         DONE: begin
            // Outputs hold until the consumer takes them; req_ready stays low
            // here, so no request is accepted on the handoff edge.
            if (out_ready) begin
               valid_nxt = 1'b0;
               div0_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         q         <= '0;
         b         <= '0;
         p         <= '0;
         cnt       <= '0;
         id        <= 1'b0;
         out_valid <= 1'b0;
         out_quot  <= '0;
         out_rem   <= '0;
         out_id    <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         q         <= q_nxt;
         b         <= b_nxt;
         p         <= p_nxt;
         cnt       <= cnt_nxt;
         id        <= id_nxt;
         out_valid <= valid_nxt;
         out_quot  <= quot_nxt;
         out_rem   <= rem_nxt;
         out_id    <= oid_nxt;
         div0_q    <= div0_nxt;
      end
   end

endmodule
